ped_request_conditioner: RTL and testbench
==========================================

// Module: ped_request_conditioner
// PURPOSE
//  Conditions the raw pedestrian push-button ahead of the two-way semaphore controller.
//  - Synchronises the button, debounces it and turns each clean press into one request.
//  - Holds that request on req, which drives the controller's bt input, until the controller acknowledges it.
//  - Enforces a lockout window after each acknowledge and counts the presses it ignores.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive clk cycles a synchronised level must hold before it is accepted (>=1)
//  LOCKOUT_CYCLES   8  clk cycles after ack during which new presses are ignored (>=1)
//  CNT_W            4  width of the internal debounce/lockout counters; must hold max(DEBOUNCE_CYCLES,LOCKOUT_CYCLES)
// PORTS
//  clk       in   1  system clock, rising-edge active
//  rst       in   1  asynchronous, active-low reset
//  bt_raw    in   1  raw push-button level, asynchronous to clk, may bounce
//  ack       in   1  controller acknowledge, synchronous to clk; sampled only in PENDING
//  req       out  1  registered request level to controller bt; high from accepted press until ack
//  press     out  1  registered one-cycle pulse per debounced rising edge, regardless of state
//  state     out  2  FSM state: 00=IDLE 01=PENDING 10=LOCKOUT (11 unused)
//  drop_cnt  out  8  saturating count of presses ignored in PENDING or LOCKOUT
// BEHAVIOUR
//  Reset (rst=0, async):
//   - sync1, sync2, db_level, db_prev, counters, req, press cleared to 0.
//   - state=IDLE, drop_cnt=0.
//   - Takes effect immediately, even mid-debounce or mid-lockout.
//  Synchroniser: two flops, bt_raw -> sync1 -> sync2.
//  Debounce:
//   - sync2==db_level -> db_cnt<=0.
//   - Otherwise db_cnt increments. When db_cnt==DEBOUNCE_CYCLES-1 while still differing: db_level<=sync2, db_cnt<=0.
//   - Any glitch shorter than DEBOUNCE_CYCLES restarts the count. Falling edges are debounced identically.
//  Edge detect:
//   - db_prev<=db_level each cycle.
//   - press_evt = db_level & ~db_prev; press<=press_evt.
//  Latency: bt_raw held high from edge 1 gives press=req=1 after edge DEBOUNCE_CYCLES+3 (edge 7 at default).
//  FSM (req and state are registered; req=1 exactly in PENDING):
//   - IDLE:    press_evt -> PENDING. ack ignored.
//   - PENDING: ack=1 -> LOCKOUT, lk_cnt<=0. press_evt without ack -> drop_cnt++, stay. Simultaneous ack and press_evt -> ack wins, press dropped (drop_cnt++).
//   - LOCKOUT: lk_cnt++ each cycle. lk_cnt==LOCKOUT_CYCLES-1 -> IDLE. press_evt -> drop_cnt++. ack ignored.
//   - A press_evt on the exit cycle of LOCKOUT is dropped, not queued.
//   - Illegal state 11 -> IDLE on next edge; req=0.
//  drop_cnt: 8-bit, saturates at 255, never wraps. Cleared only by reset.
//  A button held through reset release yields exactly one press after debounce.
//  Holding the button produces no repeat presses; a release must be debounced before a new press.
// TESTING
//  1. Reset, bt_raw 0->1 held: press one-cycle pulse and req=1 after edge 7; state=01; held 20 cycles -> no second press.
//  2. Bounce 1,0,1,1,0 cycles then steady 1: no press until 4 consecutive stable sync2 cycles; exactly one press total.
//  3. req=1, ack pulse 1 cycle: req=0 next edge, state=10 for 8 cycles, then 00; a press during LOCKOUT -> drop_cnt=1, req stays 0.
//  4. In PENDING, press_evt and ack on same edge: state->10, req->0, drop_cnt+1.
//  5. 300 presses while held in PENDING (ack=0): drop_cnt saturates at 255, req stays 1.
//  6. rst=0 mid-LOCKOUT and mid-debounce: all outputs 0 and state=00 immediately; release with bt_raw=1 -> one press after debounce latency.

Source files
------------

// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner: synchronise, debounce, edge-detect, then hold
// one request per accepted press until acknowledged, with a post-ack lockout window.
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt_raw,
  input  logic       ack,
  output logic       req,
  output logic       press,
  output logic [1:0] state,
  output logic [7:0] drop_cnt
);

  // state   | meaning
  // IDLE    | no request outstanding, waiting for a debounced press
  // PENDING | request held on req until the controller acks
  // LOCKOUT | post-ack window, presses are counted as dropped
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PENDING = 2'b01,
    S_LOCKOUT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_level_q, db_level_d;
  logic             db_prev_q, db_prev_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] lk_cnt_q, lk_cnt_d;
  logic             req_q, req_d;
  logic             press_q, press_d;
  state_t           state_q, state_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic             press_evt;
  logic             drop_inc;

  always_comb begin
    sync1_d    = bt_raw;
    sync2_d    = sync1_q;
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    // the count only survives while the synchronised level keeps disagreeing
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) db_level_d = sync2_q;
      else                     db_cnt_d   = db_cnt_q + 1'b1;
    end
    db_prev_d = db_level_q;
    press_evt = db_level_q & ~db_prev_q;
    press_d   = press_evt;

    state_d  = state_q;
    lk_cnt_d = lk_cnt_q;
    drop_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_evt) state_d = S_PENDING;
      end
      S_PENDING: begin
        // ack has priority; a coincident press is lost and counted
        drop_inc = press_evt;
        if (ack) begin
          state_d  = S_LOCKOUT;
          lk_cnt_d = '0;
        end
      end
      S_LOCKOUT: begin
        drop_inc = press_evt;
        if (lk_cnt_q == LK_LAST) state_d = S_IDLE;
        else                     lk_cnt_d = lk_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    drop_cnt_d = drop_cnt_q;
    if (drop_inc && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    req_d = (state_d == S_PENDING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      lk_cnt_q   <= '0;
      req_q      <= 1'b0;
      press_q    <= 1'b0;
      state_q    <= S_IDLE;
      drop_cnt_q <= 8'd0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_prev_d;
      db_cnt_q   <= db_cnt_d;
      lk_cnt_q   <= lk_cnt_d;
      req_q      <= req_d;
      press_q    <= press_d;
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign req      = req_q;
  assign press    = press_q;
  assign state    = state_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner: directed scenarios plus random button/ack
// traffic, all compared against a behavioural model of the button rules.
module tb_ped_request_conditioner;

  localparam int DEB = 4;
  localparam int LK  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bt_raw = 1'b0;
  logic       ack = 1'b0;
  logic       req;
  logic       press;
  logic [1:0] state;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .LOCKOUT_CYCLES (LK),
    .CNT_W          (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bt_raw  (bt_raw),
    .ack     (ack),
    .req     (req),
    .press   (press),
    .state   (state),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Model: sync pipeline as two sampled bits, debounced level flips once the last
  // DEB synchronised samples all disagree with it; lockout as cycles remaining.
  bit       m_s1, m_s2, m_level, m_rose, m_press, m_req;
  bit       hist[$];
  bit [1:0] m_mode;
  int       m_remain;
  int       m_drop;

  logic [11:0] got;
  logic [11:0] exp_v;
  assign got   = {req, press, state, drop_cnt};
  assign exp_v = {m_req, m_press, m_mode, 8'(m_drop)};

  function void model_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_rose = 0; m_press = 0; m_req = 0;
    m_mode = 2'd0; m_remain = 0; m_drop = 0;
    hist.delete();
  endfunction

  function void model_edge();
    bit evt, flip, new_level;
    evt = m_rose;
    hist.push_back(m_s2);
    if (hist.size() > DEB) void'(hist.pop_front());
    flip = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] == m_level) flip = 0;
    new_level = flip ? ~m_level : m_level;
    case (m_mode)
      2'd0: if (evt) m_mode = 2'd1;
      2'd1: begin
        if (evt && m_drop < 255) m_drop++;
        if (ack) begin m_mode = 2'd2; m_remain = LK; end
      end
      default: begin
        if (evt && m_drop < 255) m_drop++;
        m_remain--;
        if (m_remain == 0) m_mode = 2'd0;
      end
    endcase
    m_press = evt;
    m_req   = (m_mode == 2'd1);
    m_s2    = m_s1;
    m_s1    = bt_raw;
    m_rose  = new_level & ~m_level;
    m_level = new_level;
  endfunction

  // Advance one clock; outputs are settled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic do_reset(input bit level);
    ack = 1'b0;
    bt_raw = level;
    rst = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    bt_raw = 1'b1;
    repeat (9) step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected 000", got);
    end
    model_reset();
    repeat (2) step();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_held: got %h expected 000", got);
    end
    rst = 1'b1;
    bt_raw = 1'b0;
  endtask

  task automatic test_press_latency();
    int presses = 0;
    do_reset(1'b0);
    bt_raw = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      step();
      presses += int'(press);
      n_checks++;
      if (press !== (i == 7) || req !== (i >= 7) || state !== ((i >= 7) ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL latency edge %0d: press=%b req=%b state=%b expected press=%b req=%b", i, press, req, state, i == 7, i >= 7);
      end
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL latency_model edge %0d: got %h expected %h", i, got, exp_v);
      end
    end
    n_checks++;
    if (presses != 1) begin
      n_fail++;
      $display("FAIL latency_press_count: got %0d expected 1", presses);
    end
  endtask

  task automatic test_bounce();
    bit pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int presses = 0;
    int first = 0;
    do_reset(1'b0);
    for (int i = 1; i <= 30; i++) begin
      bt_raw = (i <= 5) ? pat[i-1] : 1'b1;
      step();
      if (press === 1'b1) begin
        presses++;
        if (first == 0) first = i;
      end
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL bounce_model edge %0d: got %h expected %h", i, got, exp_v);
      end
    end
    n_checks++;
    if (presses != 1 || first != 12) begin
      n_fail++;
      $display("FAIL bounce_press: got count=%0d first=%0d expected count=1 first=12", presses, first);
    end
  endtask

  task automatic test_lockout();
    do_reset(1'b0);
    bt_raw = 1'b1;
    repeat (7) step();
    bt_raw = 1'b0;
    repeat (8) step();
    bt_raw = 1'b1;
    repeat (3) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_checks++;
    if (req !== 1'b0 || state !== 2'b10) begin
      n_fail++;
      $display("FAIL lockout_enter: req=%b state=%b expected req=0 state=10", req, state);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      n_checks++;
      if (state !== ((i < LK) ? 2'b10 : 2'b00) || req !== 1'b0) begin
        n_fail++;
        $display("FAIL lockout_window cycle %0d: state=%b req=%b expected state=%b req=0", i, state, req, (i < LK) ? 2'b10 : 2'b00);
      end
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL lockout_model cycle %0d: got %h expected %h", i, got, exp_v);
      end
    end
    n_checks++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL lockout_drop: got %0d expected 1", drop_cnt);
    end
  endtask

  task automatic test_ack_press_same();
    bit found = 0;
    do_reset(1'b0);
    bt_raw = 1'b1;
    repeat (7) step();
    bt_raw = 1'b0;
    repeat (8) step();
    bt_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (m_rose) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL ack_press_timeout: got no debounced rise expected one within 20 cycles");
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    n_checks++;
    if (state !== 2'b10 || req !== 1'b0 || drop_cnt !== 8'd1 || press !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_press_same: state=%b req=%b drop=%0d press=%b expected 10 0 1 1", state, req, drop_cnt, press);
    end
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL ack_press_model: got %h expected %h", got, exp_v);
    end
  endtask

  task automatic test_saturate();
    do_reset(1'b0);
    bt_raw = 1'b1;
    repeat (7) step();
    bt_raw = 1'b0;
    repeat (6) step();
    for (int p = 0; p < 300; p++) begin
      for (int c = 0; c < 12; c++) begin
        bt_raw = (c < 6);
        step();
        n_checks++;
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL saturate_model press %0d: got %h expected %h", p, got, exp_v);
        end
      end
    end
    n_checks++;
    if (drop_cnt !== 8'd255 || req !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate_final: drop=%0d req=%b expected 255 1", drop_cnt, req);
    end
  endtask

  task automatic test_reset_mid();
    int presses = 0;
    do_reset(1'b0);
    bt_raw = 1'b1;
    repeat (7) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    repeat (3) step();
    bt_raw = 1'b0;
    repeat (2) step();
    bt_raw = 1'b1;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (got !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected 000", got);
    end
    repeat (3) step();
    rst = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      presses += int'(press);
      n_checks++;
      if (press !== (i == 7) || got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid_release edge %0d: got %h expected %h press_expected=%b", i, got, exp_v, i == 7);
      end
    end
    n_checks++;
    if (presses != 1) begin
      n_fail++;
      $display("FAIL reset_mid_press_count: got %0d expected 1", presses);
    end
  endtask

  task automatic test_random();
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bt_raw = ~bt_raw;
      ack = ($urandom_range(0, 3) == 0);
      step();
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %h expected %h", i, got, exp_v);
      end
    end
    ack = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_press_latency();
    test_bounce();
    test_lockout();
    test_ack_press_same();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
